am_controller: RTL and testbench

Sequencer for the associative-memory (AM) search stage. It steps through the chunks of the query/class hypervectors, issuing chunk reads and driving the accumulate/hold/clear controls shared by the NUM_CLASSES per-class tree adders. When accumulation finishes, it scans the similarity values serially and returns the argmax class. It sits between the top-level inference FSM (start/done) and the AM datapath (class memory plus tree-adder array).

---
 rtl/am_controller.sv | 148 ++++++++++++++
 tb/tb_am_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_controller.sv
// am_controller: sequencer for the associative-memory search stage.
// It streams chunk reads to the class memory and drives the shared
// accumulate/hold/clear controls of the per-class tree adders. It then
// scans the held similarity values serially and reports the argmax class.
module am_controller #(
  parameter int NUM_CLASSES = 26,
  parameter int NUM_CHUNKS  = 10,
  parameter int SIM_W       = 13,
  parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter int ADDR_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            chunk_addr,
  output logic                         comparing_query_hv_with_class_hv,
  output logic                         inferring_class,
  input  logic [NUM_CLASSES*SIM_W-1:0] similarity_values,
  output logic                         done,
  output logic [IDX_W-1:0]             class_out,
  output logic [SIM_W-1:0]             class_sim
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    TAIL,
    ARGMAX,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] chunk_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  best_idx;
  logic [SIM_W-1:0]  best_sim;
  logic [SIM_W-1:0]  sim_arr [NUM_CLASSES];
  logic [SIM_W-1:0]  scan_sim;
  logic              last_chunk;
  logic              last_class;
  logic              take;
  // Read strobe delayed by the 1-cycle memory latency: accumulate enable.
  logic              rd_en_p1;

  // Index 0 always wins so the scan seeds itself; later entries must be
  // strictly larger, which keeps the lowest index on ties.
  function automatic logic is_better(input logic             first,
                                     input logic [SIM_W-1:0] cand,
                                     input logic [SIM_W-1:0] best);
    return first || (cand > best);
  endfunction

  // Unpack the flattened adder outputs and select the entry being scanned.
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      sim_arr[k] = similarity_values[k*SIM_W +: SIM_W];
    end
    scan_sim   = sim_arr[scan_idx];
    last_chunk = (chunk_cnt == ADDR_W'(NUM_CHUNKS - 1));
    last_class = (scan_idx == IDX_W'(NUM_CLASSES - 1));
    take       = is_better(scan_idx == '0, scan_sim, best_sim);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and decoded control outputs.
  always_comb begin
    state_nxt       = state;
    busy            = 1'b1;
    mem_rd_en       = 1'b0;
    inferring_class = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        if (last_chunk) state_nxt = TAIL;
      end
      TAIL: begin
        state_nxt = ARGMAX;
      end
      ARGMAX: begin
        inferring_class = 1'b1;
        if (last_class) state_nxt = DONE;
      end
      DONE: begin
        inferring_class = 1'b1;
        done            = 1'b1;
        state_nxt       = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign chunk_addr                       = chunk_cnt;
  assign comparing_query_hv_with_class_hv = rd_en_p1;

  // Chunk counter, accumulate-enable pipeline, argmax scan and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_cnt <= '0;
      rd_en_p1  <= 1'b0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_sim  <= '0;
      class_out <= '0;
      class_sim <= '0;
    end else begin
      rd_en_p1 <= mem_rd_en;

      if (state == FETCH && !last_chunk) begin
        chunk_cnt <= chunk_cnt + ADDR_W'(1);
      end else begin
        chunk_cnt <= '0;
      end

      if (state == ARGMAX) begin
        scan_idx <= last_class ? '0 : scan_idx + IDX_W'(1);
        if (take) begin
          best_idx <= scan_idx;
          best_sim <= scan_sim;
        end
        if (last_class) begin
          class_out <= take ? scan_idx : best_idx;
          class_sim <= take ? scan_sim : best_sim;
        end
      end else begin
        scan_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_am_controller.sv
// Self-checking bench for am_controller: an adder-array model feeds the
// DUT, expected argmax results go into a queue, a monitor checks them.
module tb_am_controller;

  localparam int NUM_CLASSES = 26;
  localparam int NUM_CHUNKS  = 10;
  localparam int SIM_W       = 13;
  localparam int IDX_W       = 5;
  localparam int ADDR_W      = 4;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         start = 1'b0;
  logic                         busy;
  logic                         mem_rd_en;
  logic [ADDR_W-1:0]            chunk_addr;
  logic                         comparing;
  logic                         inferring;
  logic [NUM_CLASSES*SIM_W-1:0] sim_flat;
  logic                         done;
  logic [IDX_W-1:0]             class_out;
  logic [SIM_W-1:0]             class_sim;

  am_controller #(
    .NUM_CLASSES(NUM_CLASSES),
    .NUM_CHUNKS (NUM_CHUNKS),
    .SIM_W      (SIM_W),
    .IDX_W      (IDX_W),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .start                            (start),
    .busy                             (busy),
    .mem_rd_en                        (mem_rd_en),
    .chunk_addr                       (chunk_addr),
    .comparing_query_hv_with_class_hv (comparing),
    .inferring_class                  (inferring),
    .similarity_values                (sim_flat),
    .done                             (done),
    .class_out                        (class_out),
    .class_sim                        (class_sim)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- adder-array model ----------------
  logic [SIM_W-1:0] target [NUM_CLASSES];
  logic [SIM_W-1:0] data_q [NUM_CLASSES];
  logic [SIM_W-1:0] acc    [NUM_CLASSES];

  // Each class's target is split over the first and last chunk; any other
  // read returns 0, and a cycle without a read leaves junk (5) on the bus.
  function automatic logic [SIM_W-1:0] part(input int n, input logic [SIM_W-1:0] t);
    if (n == 0) return t >> 1;
    if (n == NUM_CHUNKS - 1) return t - (t >> 1);
    return '0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      data_q[k] <= mem_rd_en ? part(int'(chunk_addr), target[k]) : SIM_W'(5);
      if (comparing) acc[k] <= acc[k] + data_q[k];
      else if (!inferring) acc[k] <= '0;
    end
  end

  always_comb begin
    sim_flat = '0;
    for (int k = 0; k < NUM_CLASSES; k++) sim_flat[k*SIM_W +: SIM_W] = acc[k];
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [SIM_W-1:0] sim;
  } res_t;

  res_t             exp_q[$];
  res_t             exp_r;
  bit               sb_en = 1'b1;
  int               done_cnt = 0;
  logic             rst_q = 1'b0;
  logic [IDX_W-1:0] latched_idx = '0;
  logic [SIM_W-1:0] latched_sim = '0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    check("excl", longint'(comparing && inferring), 0);
    if (!busy) check("idle_clear", longint'(comparing || inferring), 0);
    if (rst_q) begin
      check("rst_busy", busy, 0);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_addr", chunk_addr, 0);
      check("rst_cmp", comparing, 0);
      check("rst_inf", inferring, 0);
      check("rst_done", done, 0);
      check("rst_class_out", class_out, 0);
      check("rst_class_sim", class_sim, 0);
      latched_idx = '0;
      latched_sim = '0;
    end else if (done) begin
      done_cnt++;
      latched_idx = class_out;
      latched_sim = class_sim;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done with class %0d sim %0d, expected no done",
                   class_out, class_sim);
        end else begin
          exp_r = exp_q.pop_front();
          check("class_out", class_out, exp_r.idx);
          check("class_sim", class_sim, exp_r.sim);
        end
      end
    end else begin
      check("class_hold", {class_out, class_sim}, {latched_idx, latched_sim});
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_once(input string name, input logic [IDX_W-1:0] ei,
                          input logic [SIM_W-1:0] es);
    int n;
    exp_q.push_back({ei, es});
    pulse_start();
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, 38);
    @(negedge clk);
  endtask

  initial begin
    int rd_cnt, rd_first, addr_bad, cmp_cnt, cmp_first, done_c, busy_last;
    int k, n, d0;
    int dcyc[3];

    for (int i = 0; i < NUM_CLASSES; i++) target[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single run with cycle-by-cycle timing checks: 100+k, class 17 = 4000.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(100 + i);
    target[17] = SIM_W'(4000);
    exp_q.push_back({IDX_W'(17), SIM_W'(4000)});
    rd_cnt = 0; rd_first = -1; addr_bad = 0; cmp_cnt = 0; cmp_first = -1;
    done_c = -1; busy_last = -1;
    pulse_start();
    for (int c = 1; c <= 40; c++) begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
        if (int'(chunk_addr) != c - 1) addr_bad++;
      end
      if (comparing) begin
        cmp_cnt++;
        if (cmp_first < 0) cmp_first = c;
      end
      if (done) done_c = c;
      if (busy) busy_last = c;
      @(negedge clk);
    end
    check("rd_cycles", rd_cnt, 10);
    check("rd_first", rd_first, 1);
    check("addr_seq_errors", addr_bad, 0);
    check("cmp_cycles", cmp_cnt, 10);
    check("cmp_first", cmp_first, 2);
    check("done_cycle", done_c, 38);
    check("busy_last", busy_last, 38);

    // All zero similarities.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = '0;
    run_once("all_zero", 0, 0);

    // Tie between 3 and 20 keeps the lower index.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(10 + i);
    target[3] = SIM_W'(999);
    target[20] = SIM_W'(999);
    run_once("tie", 3, 999);

    // Maximum at the last index only.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(3 * i);
    target[25] = SIM_W'(2000);
    run_once("max_last", 25, 2000);

    // Everything equal: index 0 wins.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(500);
    run_once("all_equal", 0, 500);

    // start held high: three back-to-back runs, done every 39 cycles.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(1000 - 10 * i);
    repeat (3) exp_q.push_back({IDX_W'(0), SIM_W'(1000)});
    d0 = done_cnt;
    k = 0;
    n = 0;
    start = 1'b1;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        dcyc[k] = n;
        k++;
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_runs", k, 3);
    if (k == 3) begin
      check("held_period_1", dcyc[1] - dcyc[0], 39);
      check("held_period_2", dcyc[2] - dcyc[1], 39);
    end
    repeat (50) @(negedge clk);
    check("held_done_count", done_cnt - d0, 3);

    // start pulses during FETCH, ARGMAX and DONE are ignored.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(50);
    target[9] = SIM_W'(4999);
    exp_q.push_back({IDX_W'(9), SIM_W'(4999)});
    d0 = done_cnt;
    pulse_start();                 // now in cycle 1
    repeat (3) @(negedge clk);     // cycle 4, FETCH
    pulse_start();
    repeat (14) @(negedge clk);    // cycle 19, ARGMAX
    pulse_start();
    repeat (18) @(negedge clk);    // cycle 38, DONE
    check("pulse_done_cycle", done, 1);
    pulse_start();
    repeat (60) @(negedge clk);
    check("pulse_done_count", done_cnt - d0, 1);

    // Abort in FETCH cycle 5, then a clean run.
    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(200 + (i % 7) * 100);
    target[12] = SIM_W'(3000);
    d0 = done_cnt;
    pulse_start();                 // cycle 1
    repeat (4) @(negedge clk);     // cycle 5
    check("abort_fetch_state", mem_rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_fetch_no_done", done_cnt - d0, 0);
    run_once("after_fetch_abort", 12, 3000);

    // Abort in ARGMAX cycle 10 (overall cycle 21), then a clean run.
    d0 = done_cnt;
    pulse_start();
    repeat (20) @(negedge clk);    // cycle 21
    check("abort_argmax_state", inferring, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_argmax_no_done", done_cnt - d0, 0);
    run_once("after_argmax_abort", 12, 3000);

    // Random start/rst traffic; monitor keeps checking control exclusivity.
    sb_en = 1'b0;
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb_en = 1'b1;

    for (int i = 0; i < NUM_CLASSES; i++) target[i] = SIM_W'(100 + i);
    target[17] = SIM_W'(4000);
    run_once("after_random", 17, 4000);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
